// File: rtl/addr_u_tr_pkg.sv
// Shared types and constants for the chunk-serial adder
// with temporal-redundancy fault detection.
package addr_u_tr_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_P2,
    S_CMP,
    S_OUT
  } state_e;

  localparam int MODE_SINGLE = 0;
  localparam int MODE_CHECK  = 1;
  localparam int MODE_RETRY  = 2;

  // Number of CHUNK-bit slices needed to cover WIDTH bits.
  function automatic int nch(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // Bit width able to hold 0..n, never less than one bit.
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/addr_u_chunk_add.sv
// CHUNK-bit adder slice with carry in/out; one copy is
// shared by both passes of the serial adder.
module addr_u_chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK:0] s;

  // Plain ripple add, widened by one bit for the carry.
  always_comb begin
    s = {1'b0, a_i}
      + {1'b0, b_i}
      + {{CHUNK{1'b0}}, cin_i};
  end

  assign sum_o  = s[CHUNK-1:0];
  assign cout_o = s[CHUNK];

endmodule

// File: rtl/addr_u_tr_seq.sv
// Chunk-serial unsigned adder; optional second pass on
// inverted operands detects faults, with optional retry.
module addr_u_tr_seq
  import addr_u_tr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHUNK     = 4,
  parameter int MODE      = 2,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH:0]             out_sum,
  output logic                       out_err,
  output logic [CNT_W-1:0]           err_count,
  input  logic                       fi_en,
  input  logic [$clog2(WIDTH+1)-1:0] fi_pos,
  input  logic                       fi_pass
);

  localparam int NCH   = nch(WIDTH, CHUNK);
  localparam int KW    = cw(NCH - 1);
  localparam int PW    = $clog2(WIDTH + 1);
  localparam int RW    = cw(MAX_RETRY);
  localparam int LASTW = WIDTH - (NCH - 1) * CHUNK;

  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);
  localparam logic [RW-1:0] RMAX  = RW'(MAX_RETRY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic [WIDTH:0]   r1_q, r1_d;
  logic [WIDTH:0]   r2_q, r2_d;
  logic [RW-1:0]    rty_q, rty_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fen_q, fen_d;
  logic [PW-1:0]    fpos_q, fpos_d;
  logic             fpass_q, fpass_d;

  logic             pass2;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic             cin;
  logic [CHUNK-1:0] sum_ch;
  logic             cout;
  logic             flt;
  logic [WIDTH:0]   r_w;
  logic             last;
  logic             mism;

  // Operand slice selection; pass 2 adds ~A + ~B + 1.
  always_comb begin
    pass2 = (state_q == S_P2);
    op_a  = pass2 ? ~a_q : a_q;
    op_b  = pass2 ? ~b_q : b_q;
    a_ch  = CHUNK'(op_a >> (int'(k_q) * CHUNK));
    b_ch  = CHUNK'(op_b >> (int'(k_q) * CHUNK));
    cin   = (k_q == '0) ? pass2 : c_q;
    last  = (k_q == KLAST);
  end

  addr_u_chunk_add #(
    .CHUNK (CHUNK)
  ) u_add (
    .a_i    (a_ch),
    .b_i    (b_ch),
    .cin_i  (cin),
    .sum_o  (sum_ch),
    .cout_o (cout)
  );

  // Merge the current slice into the active result register;
  // top bit comes from the zero-extended last slice.
  always_comb begin
    r_w = pass2 ? r2_q : r1_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i / CHUNK == int'(k_q)) begin
        r_w[i] = sum_ch[i % CHUNK];
      end
    end
    if (last) begin
      r_w[WIDTH] = (LASTW == CHUNK) ? cout
                 : sum_ch[LASTW % CHUNK];
    end
    flt = fen_q && (fpass_q == pass2);
    for (int i = 0; i <= WIDTH; i++) begin
      if (flt && fpos_q == PW'(i)) begin
        r_w[i] = 1'b1;
      end
    end
  end

  assign mism = (r1_q != ~r2_q);

  // Sequencing: passes, compare, retry decision, output hold.
  // Fault controls are re-sampled on every retry so that a
  // transient fault can clear between attempts.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    k_d     = k_q;
    c_d     = c_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    rty_d   = rty_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    fen_d   = fen_q;
    fpos_d  = fpos_q;
    fpass_d = fpass_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          fen_d   = fi_en;
          fpos_d  = fi_pos;
          fpass_d = fi_pass;
          k_d     = '0;
          rty_d   = '0;
          state_d = S_P1;
        end
      end
      S_P1: begin
        r1_d = r_w;
        c_d  = cout;
        if (last) begin
          k_d = '0;
          if (MODE == MODE_SINGLE) begin
            err_d   = 1'b0;
            state_d = S_OUT;
          end else begin
            state_d = S_P2;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_P2: begin
        r2_d = r_w;
        c_d  = cout;
        if (last) begin
          k_d     = '0;
          state_d = S_CMP;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_CMP: begin
        if (mism && cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (MODE == MODE_RETRY && mism
            && rty_q < RMAX) begin
          rty_d   = rty_q + RW'(1);
          k_d     = '0;
          fen_d   = fi_en;
          fpos_d  = fi_pos;
          fpass_d = fi_pass;
          state_d = S_P1;
        end else begin
          err_d   = mism;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          rty_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      r1_q    <= '0;
      r2_q    <= '0;
      rty_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      fen_q   <= 1'b0;
      fpos_q  <= '0;
      fpass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      c_q     <= c_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      rty_q   <= rty_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      fen_q   <= fen_d;
      fpos_q  <= fpos_d;
      fpass_q <= fpass_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_OUT);
  assign out_sum   = out_valid ? r1_q : '0;
  assign out_err   = out_valid && err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_addr_u_tr_seq.sv
// Bench for addr_u_tr_seq: three configurations driven in
// lockstep and checked every cycle against an arithmetic model.
module tb_addr_u_tr_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic       fi_en;
  logic       fi_pass;
  logic [3:0] fi_pos;
  logic [7:0] a8, b8;
  logic [6:0] a7, b7;

  logic       ir0, ir1, ir2;
  logic       ov0, ov1, ov2;
  logic       oe0, oe1, oe2;
  logic [7:0] ec0, ec1, ec2;
  logic [8:0] os0, os1;
  logic [7:0] os7;

  logic       ir[3], ov[3], oe[3];
  logic [7:0] ec[3];
  logic [8:0] os[3];

  int         checks = 0;
  int         errors = 0;

  int         m_lat[3];
  logic [8:0] m_sum[3];
  bit         m_err[3];
  int         m_cnt[3];
  int         m_cyc;
  bit         m_active = 0;
  bit         armed = 0;

  bit         cap_seen[3];
  int         cap_lat[3];
  logic [8:0] cap_sum[3];
  logic       cap_err[3];
  logic [7:0] cap_cnt[3];

  always #5 clk = ~clk;

  addr_u_tr_seq #(
    .WIDTH(8), .CHUNK(4), .MODE(2),
    .MAX_RETRY(2), .CNT_W(8)
  ) u_m2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir0),
    .in_a(a8), .in_b(b8),
    .out_valid(ov0), .out_ready(out_ready),
    .out_sum(os0), .out_err(oe0), .err_count(ec0),
    .fi_en(fi_en), .fi_pos(fi_pos), .fi_pass(fi_pass)
  );

  addr_u_tr_seq #(
    .WIDTH(8), .CHUNK(4), .MODE(0),
    .MAX_RETRY(2), .CNT_W(8)
  ) u_m0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir1),
    .in_a(a8), .in_b(b8),
    .out_valid(ov1), .out_ready(out_ready),
    .out_sum(os1), .out_err(oe1), .err_count(ec1),
    .fi_en(fi_en), .fi_pos(fi_pos), .fi_pass(fi_pass)
  );

  addr_u_tr_seq #(
    .WIDTH(7), .CHUNK(3), .MODE(1),
    .MAX_RETRY(2), .CNT_W(8)
  ) u_w7 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(ir2),
    .in_a(a7), .in_b(b7),
    .out_valid(ov2), .out_ready(out_ready),
    .out_sum(os7), .out_err(oe2), .err_count(ec2),
    .fi_en(1'b0), .fi_pos(3'd0), .fi_pass(1'b0)
  );

  assign ir[0] = ir0;
  assign ir[1] = ir1;
  assign ir[2] = ir2;
  assign ov[0] = ov0;
  assign ov[1] = ov1;
  assign ov[2] = ov2;
  assign oe[0] = oe0;
  assign oe[1] = oe1;
  assign oe[2] = oe2;
  assign ec[0] = ec0;
  assign ec[1] = ec1;
  assign ec[2] = ec2;
  assign os[0] = os0;
  assign os[1] = os1;
  assign os[2] = {1'b0, os7};

  function automatic void chk(
    input string nm, input int idx,
    input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h t=%0t",
               nm, idx, act, exp, $time);
    end
  endfunction

  // What an adder with this mode must report: retries follow
  // the compare rule, latency follows pass/compare cycle counts.
  function automatic void model(
    input int w, input int n, input int mode,
    input int maxr, input int a, input int b,
    input bit fe, input int fpos, input bit fpass,
    input bit fl, output int sum, output bit err,
    output int mm, output int lat);
    int mask, wm, t, p1, r2, f1, f2;
    bit fnow, mis;
    mask = (1 << (w + 1)) - 1;
    wm   = (1 << w) - 1;
    t    = 0;
    mm   = 0;
    sum  = 0;
    err  = 0;
    lat  = 0;
    while (1) begin
      fnow = (t == 0) ? fe : fl;
      f1 = (fnow && !fpass && fpos <= w) ? (1 << fpos) : 0;
      f2 = (fnow && fpass && fpos <= w) ? (1 << fpos) : 0;
      p1 = ((a + b) & mask) | f1;
      r2 = ((((~a) & wm) + ((~b) & wm) + 1) & mask) | f2;
      if (mode == 0) begin
        sum = p1;
        err = 0;
        lat = n + 1;
        break;
      end
      mis = (p1 != ((~r2) & mask));
      if (mis) mm++;
      if (mode == 2 && mis && t < maxr) begin
        t++;
      end else begin
        sum = p1;
        err = mis;
        lat = 2 * n + 2 + t * (2 * n + 1);
        break;
      end
    end
  endfunction

  task automatic put(input int i, input int s,
                     input bit e, input int mm, input int l);
    m_sum[i] = 9'(s);
    m_err[i] = e;
    m_lat[i] = l;
    m_cnt[i] = (m_cnt[i] + mm > 255) ? 255 : m_cnt[i] + mm;
  endtask

  task automatic start_model(
    input logic [7:0] a, input logic [7:0] b,
    input logic [6:0] c, input logic [6:0] d,
    input bit fe, input int fpos, input bit fpass,
    input bit fl);
    int s, mm, l;
    bit e;
    model(8, 2, 2, 2, int'(a), int'(b), fe, fpos, fpass,
          fl, s, e, mm, l);
    put(0, s, e, mm, l);
    model(8, 2, 0, 2, int'(a), int'(b), fe, fpos, fpass,
          fl, s, e, mm, l);
    put(1, s, e, mm, l);
    model(7, 3, 1, 2, int'(c), int'(d), 1'b0, 0, 1'b0,
          1'b0, s, e, mm, l);
    put(2, s, e, mm, l);
  endtask

  task automatic txn(
    input logic [7:0] a, input logic [7:0] b,
    input logic [6:0] c, input logic [6:0] d,
    input bit fe, input int fpos, input bit fpass,
    input bit drop, input int hold, input bit noise);
    int mx;
    @(negedge clk);
    a8 = a;
    b8 = b;
    a7 = c;
    b7 = d;
    fi_en = fe;
    fi_pos = 4'(fpos);
    fi_pass = fpass;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    start_model(a, b, c, d, fe, fpos, fpass, drop ? 1'b0 : fe);
    m_cyc = 0;
    for (int i = 0; i < 3; i++) cap_seen[i] = 0;
    m_active = 1;
    if (noise) begin
      a8 = ~a;
      b8 = 8'h11;
      a7 = ~c;
    end else begin
      in_valid = 1'b0;
    end
    if (drop) fi_en = 1'b0;
    mx = m_lat[0];
    for (int i = 1; i < 3; i++)
      if (m_lat[i] > mx) mx = m_lat[i];
    repeat (mx + hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    fi_en = 1'b0;
    m_active = 0;
  endtask

  // Per-cycle comparison of all three instances to the model.
  always @(negedge clk) begin
    if (armed && !rst) begin
      if (m_active) begin
        m_cyc = m_cyc + 1;
        for (int i = 0; i < 3; i++) begin
          chk("busy_in_ready", i, 32'(ir[i]), 0);
          chk("out_valid", i, 32'(ov[i]),
              32'(m_cyc >= m_lat[i]));
          if (ov[i]) begin
            chk("out_sum", i, 32'(os[i]), 32'(m_sum[i]));
            chk("out_err", i, 32'(oe[i]), 32'(m_err[i]));
            chk("err_count", i, 32'(ec[i]), 32'(m_cnt[i]));
            if (!cap_seen[i]) begin
              cap_seen[i] = 1;
              cap_lat[i] = m_cyc;
              cap_sum[i] = os[i];
              cap_err[i] = oe[i];
              cap_cnt[i] = ec[i];
            end
          end
        end
      end else begin
        for (int i = 0; i < 3; i++) begin
          chk("idle_valid", i, 32'(ov[i]), 0);
          chk("idle_ready", i, 32'(ir[i]), 1);
          chk("idle_count", i, 32'(ec[i]), 32'(m_cnt[i]));
        end
      end
    end
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    fi_en = 1'b0;
    fi_pos = 4'd0;
    fi_pass = 1'b0;
    a8 = '0;
    b8 = '0;
    a7 = '0;
    b7 = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 0, 32'(ir0), 0);
    chk("rst_out_valid", 0, 32'(ov0), 0);
    chk("rst_out_sum", 0, 32'(os0), 0);
    chk("rst_err_count", 0, 32'(ec0), 0);
    rst = 1'b0;
    armed = 1;

    txn(8'h5A, 8'h3C, 7'h5A, 7'h3C, 0, 0, 0, 0, 0, 0);
    chk("basic_sum", 0, 32'(cap_sum[0]), 32'h096);
    chk("basic_err", 0, 32'(cap_err[0]), 0);
    chk("basic_lat", 0, cap_lat[0], 6);
    chk("basic_cnt", 0, 32'(cap_cnt[0]), 0);
    chk("w7_basic_sum", 2, 32'(cap_sum[2]), 32'h096);
    chk("w7_lat", 2, cap_lat[2], 8);

    txn(8'hFF, 8'hFF, 7'h7F, 7'h7F, 0, 0, 0, 0, 0, 0);
    chk("wrap_sum", 0, 32'(cap_sum[0]), 32'h1FE);
    chk("w7_wrap_sum", 2, 32'(cap_sum[2]), 32'h0FE);

    txn(8'h00, 8'h00, 7'h00, 7'h00, 0, 0, 0, 0, 0, 0);
    chk("zero_sum", 0, 32'(cap_sum[0]), 32'h000);

    txn(8'h01, 8'h01, 7'h01, 7'h01, 1, 2, 0, 1, 0, 0);
    chk("trans_sum", 0, 32'(cap_sum[0]), 32'h002);
    chk("trans_err", 0, 32'(cap_err[0]), 0);
    chk("trans_cnt", 0, 32'(cap_cnt[0]), 1);
    chk("trans_lat", 0, cap_lat[0], 11);
    chk("m0_trans_sum", 1, 32'(cap_sum[1]), 32'h006);

    txn(8'h10, 8'h20, 7'h10, 7'h20, 1, 4, 1, 0, 0, 0);
    chk("pers_sum", 0, 32'(cap_sum[0]), 32'h030);
    chk("pers_err", 0, 32'(cap_err[0]), 1);
    chk("pers_cnt", 0, 32'(cap_cnt[0]), 4);
    chk("pers_lat", 0, cap_lat[0], 16);
    chk("m0_pers_err", 1, 32'(cap_err[1]), 0);

    txn(8'h12, 8'h34, 7'h12, 7'h34, 0, 0, 0, 0, 5, 1);
    chk("bp_sum", 0, 32'(cap_sum[0]), 32'h046);

    txn(8'h80, 8'h80, 7'h40, 7'h40, 1, 0, 0, 0, 0, 0);
    chk("m0_sum", 1, 32'(cap_sum[1]), 32'h101);
    chk("m0_err", 1, 32'(cap_err[1]), 0);
    chk("m0_lat", 1, cap_lat[1], 3);
    chk("m2_fault_err", 0, 32'(cap_err[0]), 1);

    @(negedge clk);
    a8 = 8'h77;
    b8 = 8'h11;
    a7 = 7'h33;
    b7 = 7'h22;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    start_model(8'h77, 8'h11, 7'h33, 7'h22, 0, 0, 0, 0);
    m_cyc = 0;
    m_active = 1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_active = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    @(negedge clk);
    chk("abort_cnt", 0, 32'(ec0), 0);
    chk("abort_ready", 0, 32'(ir0), 1);
    repeat (12) @(negedge clk);

    txn(8'h01, 8'h02, 7'h01, 7'h02, 0, 0, 0, 0, 0, 0);
    chk("recover_sum", 0, 32'(cap_sum[0]), 32'h003);

    for (int x = 0; x < 128; x++) begin
      for (int y = 0; y < 130; y += 5) begin
        int yy;
        yy = (y > 127) ? 127 : y;
        txn(8'(x * 2 + (yy & 1)), 8'(255 - yy),
            7'(x), 7'(yy), 0, 0, 0, 0, 0, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
